// File: rtl/gmii_rx_frame_parser.sv
// GMII receive parser: strips preamble/SFD, checks length and CRC-32, drops the FCS
// and streams frame bytes out with sof/eof/err markers plus saturating frame counters.
module gmii_rx_frame_parser #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_err,
  output logic             o_crc_ok,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q;
  logic [7:0]       buf_q [5];
  logic [2:0]       fill_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [LEN_W-1:0] len_q;
  logic             rxer_q;
  logic             emitted_q;
  logic             inc_good_q;
  logic             inc_bad_q;
  logic             crc_ok_d;
  logic             err_d;

  always_comb begin
    crc_d    = crc_byte(crc_q, gmii_rxd);
    crc_ok_d = (crc_q == CRC_RESIDUE);
    err_d    = !crc_ok_d || (len_q < LEN_MIN) || (len_q > LEN_MAX) || rxer_q;
  end

  // Delay line holding the last 5 bytes; the 4 youngest at end of frame are the FCS.
  always_ff @(posedge clk) begin
    if (state_q == DATA && gmii_rx_dv) begin
      buf_q[0] <= gmii_rxd;
      for (int i = 1; i < 5; i++) begin
        buf_q[i] <= buf_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      crc_q      <= CRC_INIT;
      len_q      <= '0;
      rxer_q     <= 1'b0;
      emitted_q  <= 1'b0;
      inc_good_q <= 1'b0;
      inc_bad_q  <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_err      <= 1'b0;
      o_crc_ok   <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_err      <= 1'b0;
      o_crc_ok   <= 1'b0;
      inc_good_q <= 1'b0;
      inc_bad_q  <= 1'b0;
      if (inc_good_q) good_cnt <= sat_inc(good_cnt);
      if (inc_bad_q)  bad_cnt  <= sat_inc(bad_cnt);

      case (state_q)
        IDLE: begin
          if (gmii_rx_dv) state_q <= (gmii_rxd == 8'h55) ? PRE : DROP;
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            state_q <= IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            state_q   <= DATA;
            crc_q     <= CRC_INIT;
            len_q     <= '0;
            fill_q    <= '0;
            rxer_q    <= 1'b0;
            emitted_q <= 1'b0;
          end else if (gmii_rxd != 8'h55) begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            crc_q <= crc_d;
            len_q <= (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
            if (gmii_rx_er) rxer_q <= 1'b1;
            if (fill_q == 3'd5) begin
              o_data    <= buf_q[4];
              o_valid   <= 1'b1;
              o_sof     <= !emitted_q;
              emitted_q <= 1'b1;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end else begin
            // End of frame: the oldest buffered byte is the last non-FCS byte.
            state_q  <= IDLE;
            o_valid  <= 1'b1;
            o_eof    <= 1'b1;
            o_crc_ok <= crc_ok_d;
            if (fill_q == 3'd5) begin
              o_data     <= buf_q[4];
              o_sof      <= !emitted_q;
              o_err      <= err_d;
              inc_good_q <= !err_d;
              inc_bad_q  <= err_d;
            end else begin
              o_data    <= '0;
              o_sof     <= 1'b1;
              o_err     <= 1'b1;
              inc_bad_q <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Bench for gmii_rx_frame_parser: frames are built with a real FCS, expected output
// bytes are queued as they are driven and matched (content and cycle) by a monitor.
module tb_gmii_rx_frame_parser;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  typedef struct {
    logic [7:0] d;
    bit         sof;
    bit         eof;
    bit         err;
    bit         crc_ok;
    bit         chk_crc;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid, o_sof, o_eof, o_err, o_crc_ok;
  logic [15:0] good_cnt, bad_cnt;
  logic [7:0]  s_data;
  logic        s_valid, s_sof, s_eof, s_err, s_crc_ok;
  logic [3:0]  s_good_cnt, s_bad_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   vcnt = 0;
  int   exp_good = 0;
  int   exp_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  gmii_rx_frame_parser #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof),
    .o_eof(o_eof), .o_err(o_err), .o_crc_ok(o_crc_ok), .good_cnt(good_cnt),
    .bad_cnt(bad_cnt));

  // Narrow-counter copy so saturation is reachable in a short run.
  gmii_rx_frame_parser #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .o_data(s_data), .o_valid(s_valid), .o_sof(s_sof),
    .o_eof(s_eof), .o_err(s_err), .o_crc_ok(s_crc_ok), .good_cnt(s_good_cnt),
    .bad_cnt(s_bad_cnt));

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      vcnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid data=%02h at cycle %0d", o_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (o_data !== mon_e.d || o_sof !== mon_e.sof || o_eof !== mon_e.eof ||
            (mon_e.eof && o_err !== mon_e.err) ||
            (mon_e.eof && mon_e.chk_crc && o_crc_ok !== mon_e.crc_ok)) begin
          errors++;
          $display("FAIL out_byte got d=%02h sof=%b eof=%b err=%b crc_ok=%b, expected d=%02h sof=%b eof=%b err=%b crc_ok=%b",
                   o_data, o_sof, o_eof, o_err, o_crc_ok,
                   mon_e.d, mon_e.sof, mon_e.eof, mon_e.err, mon_e.crc_ok);
        end
        checks++;
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL out_timing byte %02h at cycle %0d, expected cycle %0d", o_data, cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < q.size(); i++) begin
      c = c ^ {24'h0, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int n_data, input int start, output logic [7:0] fr[$]);
    logic [31:0] fcs;
    fr = {};
    for (int i = 0; i < n_data; i++) fr.push_back(8'((start + i) & 255));
    fcs = ~crc32(fr);
    for (int b = 0; b < 4; b++) fr.push_back(fcs[8*b +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int er_at, input bit fcs_good, input int gap);
    int   n;
    bit   err;
    exp_t e;
    n   = fr.size();
    err = (n < MIN_LEN) || (n > MAX_LEN) || !fcs_good || (er_at >= 0);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, fr[i], 1'(i == er_at));
      if (i < n - 4) begin
        e.d = fr[i]; e.sof = (i == 0); e.eof = (i == n - 5);
        e.err = err; e.crc_ok = fcs_good; e.chk_crc = 1'b1; e.cyc = cyc + 6;
        sb.push_back(e);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    if (n < 5) begin
      e.d = 8'h00; e.sof = 1'b1; e.eof = 1'b1; e.err = 1'b1;
      e.crc_ok = 1'b0; e.chk_crc = 1'b0; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    for (int i = 1; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
    if (err) exp_bad++; else exp_good++;
  endtask

  task automatic drain(input string name);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain %0d expected bytes never appeared, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_sof, o_eof, o_err, o_crc_ok, o_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {o_valid, o_sof, o_eof, o_err, o_crc_ok, o_data});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_counters got good=%0d bad=%0d required 0/0", good_cnt, bad_cnt);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid got %b required 0", o_valid);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] f[$];
    int v0;
    v0 = vcnt;
    build(60, 0, f);
    send_frame(f, -1, 1'b1, 4);
    drain("good64");
    checks++;
    if (vcnt - v0 !== 60) begin
      errors++;
      $display("FAIL good64_count got %0d valid cycles required 60", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL good64_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_crc_error();
    logic [7:0] f[$];
    int v0;
    v0 = vcnt;
    build(60, 0, f);
    f[20] = f[20] ^ 8'h04;
    send_frame(f, -1, 1'b0, 4);
    drain("crcerr");
    checks++;
    if (vcnt - v0 !== 60) begin
      errors++;
      $display("FAIL crcerr_count got %0d valid cycles required 60", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL crcerr_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_length();
    logic [7:0] f[$];
    int v0;
    f = {8'hAA, 8'hBB, 8'hCC};
    v0 = vcnt;
    send_frame(f, -1, 1'b0, 4);
    drain("short");
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL short_count got %0d valid cycles required 1", vcnt - v0);
    end
    build(1515, 7, f);
    v0 = vcnt;
    send_frame(f, -1, 1'b1, 4);
    drain("oversize");
    checks++;
    if (vcnt - v0 !== 1515) begin
      errors++;
      $display("FAIL oversize_count got %0d valid cycles required 1515", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL length_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_rx_er();
    logic [7:0] f[$];
    int v0;
    build(96, 3, f);
    v0 = vcnt;
    send_frame(f, 40, 1'b1, 4);
    drain("rxer");
    checks++;
    if (vcnt - v0 !== 96) begin
      errors++;
      $display("FAIL rxer_count got %0d valid cycles required 96", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL rxer_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_bad_preamble();
    logic [7:0] f[$];
    int v0;
    v0 = vcnt;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drain("badpre");
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++;
      $display("FAIL badpre_valid got %0d valid cycles required 0", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL badpre_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
    build(64, 9, f);
    send_frame(f, -1, 1'b1, 4);
    drain("afterpre");
    checks++;
    if (good_cnt !== 16'(exp_good)) begin
      errors++;
      $display("FAIL afterpre_good got %0d required %0d", good_cnt, exp_good);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$];
    exp_t e;
    build(60, 0, f);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, f[i], 1'b0);
      e.d = f[i]; e.sof = (i == 0); e.eof = 1'b0; e.err = 1'b0;
      e.crc_ok = 1'b0; e.chk_crc = 1'b0; e.cyc = cyc + 6;
      sb.push_back(e);
    end
    #2;
    rst_n = 1'b0;
    gmii_rx_dv = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_sof, o_eof, o_err, o_crc_ok, o_data} !== 13'h0 || good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midrst_async got outs=%h good=%0d bad=%0d required all 0",
               {o_valid, o_sof, o_eof, o_err, o_crc_ok, o_data}, good_cnt, bad_cnt);
    end
    sb.delete();
    exp_good = 0;
    exp_bad = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain("midrst");
    checks++;
    if (good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midrst_counters got good=%0d bad=%0d required 0/0", good_cnt, bad_cnt);
    end
    build(60, 0, f);
    send_frame(f, -1, 1'b1, 4);
    drain("postrst");
    checks++;
    if (good_cnt !== 16'h1 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL postrst_counters got good=%0d bad=%0d required 1/0", good_cnt, bad_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    int v0;
    build(60, 16, f1);
    build(80, 100, f2);
    v0 = vcnt;
    send_frame(f1, -1, 1'b1, 1);
    send_frame(f2, -1, 1'b1, 4);
    drain("b2b");
    checks++;
    if (vcnt - v0 !== 140) begin
      errors++;
      $display("FAIL b2b_count got %0d valid cycles required 140", vcnt - v0);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL b2b_counters got good=%0d bad=%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] f[$];
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_good = 0;
    exp_bad = 0;
    build(60, 5, f);
    for (int k = 0; k < 17; k++) begin
      send_frame(f, -1, 1'b1, 1);
      drive(1'b0, 8'hAA, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
    end
    drain("sat");
    checks++;
    if (good_cnt !== 16'd17 || bad_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_wide got good=%0d bad=%0d required 17/0", good_cnt, bad_cnt);
    end
    checks++;
    if (s_good_cnt !== 4'hF || s_bad_cnt !== 4'h0) begin
      errors++;
      $display("FAIL sat_narrow got good=%h bad=%h required F/0", s_good_cnt, s_bad_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length();
    test_rx_er();
    test_bad_preamble();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
